// File: rtl/whack_input_decoder.sv
// Hole-switch receive path: synchronise and debounce each switch, then turn every
// accepted toggle into a whack event, arbitrated lowest-hole-first through a small FIFO.
module whack_input_decoder #(
   parameter int unsigned NUM_HOLES             = 18,
   parameter int unsigned DEBOUNCE_DELAY_COUNTS = 2500,
   parameter int unsigned FIFO_DEPTH            = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [NUM_HOLES-1:0]         switches,
   output logic [NUM_HOLES-1:0]         stable_switches,
   output logic                         whack_valid,
   output logic [$clog2(NUM_HOLES)-1:0] whack_hole,
   input  logic                         whack_ready,
   output logic                         whack_dropped
);

   localparam int unsigned HOLE_W  = $clog2(NUM_HOLES);
   localparam int unsigned CNT_W   = (DEBOUNCE_DELAY_COUNTS > 1) ? $clog2(DEBOUNCE_DELAY_COUNTS) : 1;
   localparam int unsigned CNT_MAX = DEBOUNCE_DELAY_COUNTS - 1;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTF_W  = PTR_W + 1;

   logic [NUM_HOLES-1:0] r_sync1;
   logic [NUM_HOLES-1:0] r_sync2;
   logic [NUM_HOLES-1:0] r_stable;
   logic [CNT_W-1:0]     r_cnt [NUM_HOLES];

   logic [NUM_HOLES-1:0] r_pending;
   logic [HOLE_W-1:0]    r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [CNTF_W-1:0]    r_count;
   logic                 r_valid;
   logic [HOLE_W-1:0]    r_hole;
   logic                 r_dropped;

   logic [NUM_HOLES-1:0] w_diff;
   logic [NUM_HOLES-1:0] w_flip;
   logic [HOLE_W-1:0]    w_sel;
   logic                 w_push;
   logic                 w_pop;
   logic [NUM_HOLES-1:0] w_clr;
   logic [NUM_HOLES-1:0] w_pend_nxt;
   logic                 w_drop;
   logic [CNTF_W-1:0]    w_vis_cnt;
   logic [CNTF_W-1:0]    w_count_nxt;
   logic [PTR_W-1:0]     w_rd_nxt;

   // A hole flips once its synchronised level has disagreed for the full debounce window
   always_comb begin
      w_diff = r_sync2 ^ r_stable;
      w_flip = '0;
      for (int i = 0; i < int'(NUM_HOLES); i++) begin
         w_flip[i] = w_diff[i] && (r_cnt[i] == CNT_W'(CNT_MAX));
      end
   end

   // Lowest pending hole wins
   always_comb begin
      w_sel = '0;
      for (int i = int'(NUM_HOLES) - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_sel = HOLE_W'(i);
         end
      end
   end

   assign w_push      = enable && (r_pending != '0) && (r_count < CNTF_W'(FIFO_DEPTH));
   assign w_pop       = r_valid && whack_ready;
   assign w_clr       = w_push ? (NUM_HOLES'(1) << w_sel) : '0;
   // A new flip wins over the arbiter's clear; only a still-pending hole counts as a drop
   assign w_pend_nxt  = (r_pending & ~w_clr) | (w_flip & {NUM_HOLES{enable}});
   assign w_drop      = enable && (|(w_flip & r_pending & ~w_clr));
   // Entries already stored before this edge, minus the one leaving, become visible
   assign w_vis_cnt   = r_count - CNTF_W'(w_pop);
   assign w_count_nxt = r_count + CNTF_W'(w_push) - CNTF_W'(w_pop);
   assign w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);

   // Synchroniser and per-hole debounce counters; runs regardless of enable
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         for (int i = 0; i < int'(NUM_HOLES); i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1  <= switches;
         r_sync2  <= r_sync1;
         r_stable <= r_stable ^ w_flip;
         for (int i = 0; i < int'(NUM_HOLES); i++) begin
            if (!w_diff[i] || w_flip[i]) begin
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Pending set, event FIFO and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_hole    <= '0;
         r_dropped <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (!enable) begin
         r_pending <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_pending <= w_pend_nxt;
         r_dropped <= w_drop;
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_sel;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         r_rd_ptr <= w_rd_nxt;
         r_count  <= w_count_nxt;
         r_valid  <= (w_vis_cnt != '0);
         if (w_vis_cnt != '0) begin
            r_hole <= r_mem[w_rd_nxt];
         end
      end
   end

   assign stable_switches = r_stable;
   assign whack_valid     = r_valid;
   assign whack_hole      = r_hole;
   assign whack_dropped   = r_dropped;

endmodule

// File: tb/tb_whack_input_decoder.sv
// Bench for whack_input_decoder: window/queue reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_whack_input_decoder;

   localparam int NH    = 18;
   localparam int D     = 4;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          whack_ready = 1'b0;
   logic [NH-1:0] switches = '0;
   logic [NH-1:0] stable_switches;
   logic          whack_valid;
   logic [4:0]    whack_hole;
   logic          whack_dropped;

   int n_checks = 0;
   int n_fail   = 0;

   whack_input_decoder #(
      .NUM_HOLES            (NH),
      .DEBOUNCE_DELAY_COUNTS(D),
      .FIFO_DEPTH           (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .switches       (switches),
      .stable_switches(stable_switches),
      .whack_valid    (whack_valid),
      .whack_hole     (whack_hole),
      .whack_ready    (whack_ready),
      .whack_dropped  (whack_dropped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: a switch is accepted after D consecutive samples (seen through two
   // sync stages) disagree with the accepted level; events travel through a queue.
   logic [NH-1:0] m_h [0:D] = '{default: '0};
   logic [NH-1:0] m_stable = '0;
   logic [NH-1:0] m_pend = '0;
   int            q_hole[$];
   int            q_edge[$];
   int            edge_n = 0;
   logic          m_valid = 1'b0;
   logic          m_drop = 1'b0;
   int            m_hole = 0;

   always @(posedge clk) begin : model
      logic [NH-1:0] flip;
      int            qsz;
      int            sel;
      bit            all_diff;
      edge_n = edge_n + 1;
      if (rst) begin
         for (int j = 0; j <= D; j++) m_h[j] = '0;
         m_stable = '0;
         m_pend   = '0;
         q_hole.delete();
         q_edge.delete();
         m_valid = 1'b0;
         m_drop  = 1'b0;
         m_hole  = 0;
      end else begin
         for (int i = 0; i < NH; i++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++) begin
               if (m_h[j][i] == m_stable[i]) all_diff = 1'b0;
            end
            flip[i] = all_diff;
         end
         if (!enable) begin
            m_pend = '0;
            q_hole.delete();
            q_edge.delete();
            m_valid = 1'b0;
            m_drop  = 1'b0;
         end else begin
            qsz = q_hole.size();
            if (m_valid && whack_ready) begin
               void'(q_hole.pop_front());
               void'(q_edge.pop_front());
            end
            sel = -1;
            for (int i = 0; i < NH; i++) begin
               if (m_pend[i] && sel < 0) sel = i;
            end
            if (sel >= 0 && qsz < DEPTH) begin
               q_hole.push_back(sel);
               q_edge.push_back(edge_n);
               m_pend[sel] = 1'b0;
            end
            m_drop = 1'b0;
            for (int i = 0; i < NH; i++) begin
               if (flip[i]) begin
                  if (m_pend[i]) m_drop = 1'b1;
                  m_pend[i] = 1'b1;
               end
            end
            if (q_hole.size() > 0 && q_edge[0] < edge_n) begin
               m_valid = 1'b1;
               m_hole  = q_hole[0];
            end else begin
               m_valid = 1'b0;
            end
         end
         m_stable = m_stable ^ flip;
         for (int j = D; j > 0; j--) m_h[j] = m_h[j-1];
         m_h[0] = switches;
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (edge_n > 0) begin
         chk("cyc_stable", 32'(stable_switches), 32'(m_stable));
         chk("cyc_valid", 32'(whack_valid), 32'(m_valid));
         chk("cyc_dropped", 32'(whack_dropped), 32'(m_drop));
         if (m_valid) chk("cyc_hole", 32'(whack_hole), 32'(m_hole));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp3[3] = '{0, 7, 17};
      int exp4[5] = '{1, 2, 4, 6, 8};
      int got[$];
      int drop_cnt;

      rst = 1'b1;
      tick(3);
      chk("rst_stable", 32'(stable_switches), 32'h0);
      chk("rst_valid", 32'(whack_valid), 32'h0);
      chk("rst_hole", 32'(whack_hole), 32'h0);
      chk("rst_dropped", 32'(whack_dropped), 32'h0);
      rst = 1'b0;
      enable = 1'b1;
      whack_ready = 1'b1;
      tick(2);

      // Single toggle with a ready consumer
      switches[5] = 1'b1;
      tick(5);
      chk("s1_stable_early", 32'(stable_switches[5]), 32'h0);
      tick(1);
      chk("s1_stable", 32'(stable_switches[5]), 32'h1);
      chk("s1_valid_n0", 32'(whack_valid), 32'h0);
      tick(1);
      chk("s1_valid_n1", 32'(whack_valid), 32'h0);
      tick(1);
      chk("s1_valid_n2", 32'(whack_valid), 32'h1);
      chk("s1_hole", 32'(whack_hole), 32'd5);
      tick(1);
      chk("s1_valid_gone", 32'(whack_valid), 32'h0);

      // Bounce shorter than the debounce window
      for (int k = 0; k < 10; k++) begin
         switches[3] = ~switches[3];
         tick(2);
         chk("s2_bounce_stable", 32'(stable_switches[3]), 32'h0);
      end
      switches[3] = 1'b0;
      tick(8);
      chk("s2_final_stable", 32'(stable_switches[3]), 32'h0);
      chk("s2_no_valid", 32'(whack_valid), 32'h0);

      // Simultaneous toggles, stalled consumer, then back-to-back drain
      whack_ready = 1'b0;
      switches[0] = 1'b1;
      switches[7] = 1'b1;
      switches[17] = 1'b1;
      tick(10);
      for (int k = 0; k < 3; k++) begin
         chk("s3_valid", 32'(whack_valid), 32'h1);
         chk("s3_hole", 32'(whack_hole), 32'(exp3[k]));
         whack_ready = 1'b1;
         tick(1);
      end
      chk("s3_drained", 32'(whack_valid), 32'h0);

      // Full FIFO holds the fifth event pending; re-toggling it is a drop
      whack_ready = 1'b0;
      switches[1] = ~switches[1];
      switches[2] = ~switches[2];
      switches[4] = ~switches[4];
      switches[6] = ~switches[6];
      switches[8] = ~switches[8];
      tick(12);
      chk("s4_head_valid", 32'(whack_valid), 32'h1);
      chk("s4_head_hole", 32'(whack_hole), 32'd1);
      switches[8] = ~switches[8];
      drop_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         drop_cnt += int'(whack_dropped);
      end
      chk("s4_drop_pulses", 32'(drop_cnt), 32'd1);
      whack_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (whack_valid) got.push_back(int'(whack_hole));
         tick(1);
      end
      chk("s4_count", 32'(got.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         chk("s4_order", (k < got.size()) ? 32'(got[k]) : 32'hffff_ffff, 32'(exp4[k]));
      end

      // Toggles while disabled are ignored; disabling flushes queued events
      enable = 1'b0;
      tick(1);
      switches[2] = ~switches[2];
      for (int k = 0; k < 10; k++) begin
         tick(1);
         chk("s5_no_event", 32'(whack_valid), 32'h0);
      end
      chk("s5_stable_tracks", 32'(stable_switches[2]), 32'h0);
      enable = 1'b1;
      whack_ready = 1'b0;
      switches[9] = 1'b1;
      switches[10] = 1'b1;
      tick(10);
      chk("s5_queued_valid", 32'(whack_valid), 32'h1);
      chk("s5_queued_hole", 32'(whack_hole), 32'd9);
      enable = 1'b0;
      tick(1);
      chk("s5_enable_flush", 32'(whack_valid), 32'h0);
      tick(2);
      chk("s5_still_empty", 32'(whack_valid), 32'h0);

      // Reset in the middle of a debounce, then re-debounce held switches
      enable = 1'b1;
      switches[11] = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(1);
      chk("s6_rst_stable", 32'(stable_switches), 32'h0);
      chk("s6_rst_valid", 32'(whack_valid), 32'h0);
      chk("s6_rst_hole", 32'(whack_hole), 32'h0);
      chk("s6_rst_dropped", 32'(whack_dropped), 32'h0);
      rst = 1'b0;
      whack_ready = 1'b1;
      tick(20);
      chk("s6_redebounce", 32'(stable_switches), 32'(switches));
      tick(30);
      chk("s6_drained", 32'(whack_valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
